load_store_unit: RTL and testbench

Memory-stage front end of the pipelined datapath. It sits between the EX/MEM pipeline register and the word-wide data memory. It turns byte, half and word load/store requests into word-aligned memory accesses, performing a read-modify-write for sub-word stores. It returns aligned, sign- or zero-extended load data to the MEM/WB side one cycle later, stalls the pipeline during a read-modify-write, and flags misaligned accesses.

---
 rtl/mem_pkg.sv | 33 +++
 rtl/lsu_load_extract.sv | 31 +++
 rtl/load_store_unit.sv | 128 ++++++++++++
 tb/tb_load_store_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage:
// access sizes, LSU states and store lane merging.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic {
    IDLE,
    RMW_WRITE
  } lsu_state_e;

  // Replace the addressed lane of word with
  // the low bits of data.
  function automatic logic [31:0] store_merge(
    input logic [31:0] word,
    input logic [31:0] data,
    input logic [1:0]  size,
    input logic [1:0]  addr_lo
  );
    logic [31:0] r;
    r = word;
    case (size)
      SZ_BYTE: r[{addr_lo, 3'b000} +: 8] = data[7:0];
      SZ_HALF: r[{addr_lo[1], 4'b0000} +: 16] = data[15:0];
      default: r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// Load lane select and sign/zero extension
// from a little-endian memory word.
module lsu_load_extract
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        uns,
  output logic [31:0] data
);

  logic [31:0] shifted;
  logic [7:0]  b;
  logic [15:0] h;

  assign shifted = rdata >> {addr_lo, 3'b000};
  assign b = shifted[7:0];
  assign h = shifted[15:0];

  // Pick the lane and extend it to 32 bits.
  always_comb begin
    data = rdata;
    case (size)
      SZ_BYTE: data = uns ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_HALF: data = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store front end with
// read-modify-write for sub-word stores.
module load_store_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              load_valid,
  output logic [31:0]       load_data,
  output logic              misalign,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] rmw_addr_q;
  logic [31:0]       rmw_data_q;
  logic [ADDR_W-1:0] aligned;
  logic [31:0]       ext_data;
  logic              mis;
  logic              is_load;
  logic              is_wst;
  logic              is_sub;
  logic              rd, wr, st;

  assign aligned = {req_addr[ADDR_W-1:2], 2'b00};

  // Classify the request in the EX/MEM slot.
  always_comb begin
    mis = 1'b0;
    unique case (1'b1)
      (req_size == SZ_ILL):  mis = 1'b1;
      (req_size == SZ_HALF): mis = req_addr[0];
      (req_size == SZ_WORD): mis = |req_addr[1:0];
      default:               mis = 1'b0;
    endcase
  end

  assign is_load = req_valid & ~mis & ~req_write;
  assign is_wst  = req_valid & ~mis & req_write &
                   (req_size == SZ_WORD);
  assign is_sub  = req_valid & ~mis & req_write &
                   (req_size != SZ_WORD);

  lsu_load_extract u_extract (
    .rdata   (mem_rdata),
    .size    (req_size),
    .addr_lo (req_addr[1:0]),
    .uns     (req_unsigned),
    .data    (ext_data)
  );

  // Next state and memory-side controls.
  always_comb begin
    state_d   = state_q;
    rd        = 1'b0;
    wr        = 1'b0;
    st        = 1'b0;
    mem_addr  = aligned;
    mem_wdata = 32'b0;
    unique case (state_q)
      IDLE: begin
        rd = is_load | is_sub;
        wr = is_wst;
        st = is_sub;
        if (is_wst) mem_wdata = req_wdata;
        if (is_sub) state_d = RMW_WRITE;
      end
      RMW_WRITE: begin
        wr        = 1'b1;
        mem_addr  = rmw_addr_q;
        mem_wdata = rmw_data_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!reset) begin
      rd        = 1'b0;
      wr        = 1'b0;
      st        = 1'b0;
      mem_wdata = 32'b0;
    end
  end

  assign mem_read  = rd;
  assign mem_write = wr;
  assign stall     = st;

  // State, RMW latches and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rmw_addr_q <= '0;
      rmw_data_q <= 32'b0;
      load_valid <= 1'b0;
      load_data  <= 32'b0;
      misalign   <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_valid <= 1'b0;
      misalign   <= 1'b0;
      if (state_q == IDLE) begin
        load_valid <= is_load;
        misalign   <= req_valid & mis;
        if (is_load) load_data <= ext_data;
        if (is_sub) begin
          rmw_addr_q <= aligned;
          rmw_data_q <= store_merge(mem_rdata,
                          req_wdata, req_size,
                          req_addr[1:0]);
        end
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and random checks of load_store_unit
// against a word-array reference memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b0;
  logic        req_unsigned = 1'b0;
  logic [7:0]  req_addr = 8'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        stall, load_valid, misalign;
  logic        mem_read, mem_write;
  logic [31:0] load_data, mem_wdata, mem_rdata;
  logic [7:0]  mem_addr;

  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic        init_en = 1'b1;
  int          total = 0;
  int          passed = 0;
  int          fails = 0;

  load_store_unit #(.ADDR_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall        (stall),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .misalign     (misalign),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    return 32'h9E3779B9 * (i + 1);
  endfunction

  // Environment memory: combinational read, posedge write.
  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (init_en) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (mem_write) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h",
             tag, obs, exp);
    end
  endtask

  // One request, checked cycle by cycle against
  // the reference memory.
  task automatic op(input logic w,
                    input logic [1:0] sz,
                    input logic u,
                    input logic [7:0] a,
                    input logic [31:0] d);
    logic        mis, sub, ld, wst;
    logic [31:0] old, nw, lexp, m, v;
    logic [7:0]  al;
    int          k, h;
    mis = (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
          (sz == 2'd2 && a[1:0] != 2'd0);
    ld  = !mis && !w;
    wst = !mis && w && sz == 2'd2;
    sub = !mis && w && sz != 2'd2;
    al  = {a[7:2], 2'b00};
    old = ref_mem[a[7:2]];
    k   = int'(a[1:0]);
    h   = int'(a[1]);
    nw  = old;
    lexp = old;
    if (sz == 2'd0) begin
      m  = 32'hFF << (8 * k);
      nw = (old & ~m) | ((d & 32'hFF) << (8 * k));
      v  = (old >> (8 * k)) & 32'hFF;
      if (!u && v[7]) v = v | 32'hFFFFFF00;
      lexp = v;
    end else if (sz == 2'd1) begin
      m  = 32'hFFFF << (16 * h);
      nw = (old & ~m) | ((d & 32'hFFFF) << (16 * h));
      v  = (old >> (16 * h)) & 32'hFFFF;
      if (!u && v[15]) v = v | 32'hFFFF0000;
      lexp = v;
    end else begin
      nw = d;
    end
    req_valid = 1'b1;
    req_write = w;
    req_size = sz;
    req_unsigned = u;
    req_addr = a;
    req_wdata = d;
    #1;
    check("stall", {31'b0, stall}, {31'b0, sub});
    check("mem_read", {31'b0, mem_read},
          {31'b0, ld | sub});
    check("mem_write", {31'b0, mem_write},
          {31'b0, wst});
    if (ld || sub || wst)
      check("mem_addr", {24'b0, mem_addr}, {24'b0, al});
    check("mem_wdata", mem_wdata, wst ? d : 32'h0);
    @(posedge clk);
    #1;
    if (sub) begin
      check("rmw_stall", {31'b0, stall}, 32'h0);
      check("rmw_read", {31'b0, mem_read}, 32'h0);
      check("rmw_write", {31'b0, mem_write}, 32'h1);
      check("rmw_addr", {24'b0, mem_addr}, {24'b0, al});
      check("rmw_wdata", mem_wdata, nw);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    #1;
    check("load_valid", {31'b0, load_valid},
          {31'b0, ld});
    check("misalign", {31'b0, misalign},
          {31'b0, mis});
    if (ld) check("load_data", load_data, lexp);
    if (w && !mis) ref_mem[a[7:2]] = nw;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_stall", {31'b0, stall}, 32'h0);
    check("rst_lv", {31'b0, load_valid}, 32'h0);
    check("rst_ld", load_data, 32'h0);
    check("rst_mis", {31'b0, misalign}, 32'h0);
    init_en = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;

    op(1'b1, 2'd2, 1'b0, 8'h08, 32'hDEADBEEF);
    op(1'b0, 2'd2, 1'b0, 8'h08, 32'h0);
    check("lw_dead", load_data, 32'hDEADBEEF);
    op(1'b1, 2'd2, 1'b0, 8'h08, 32'h11223344);
    op(1'b1, 2'd0, 1'b0, 8'h09, 32'h000000A5);
    op(1'b0, 2'd2, 1'b0, 8'h08, 32'h0);
    check("sb_merge", load_data, 32'h1122A544);
    op(1'b0, 2'd0, 1'b0, 8'h09, 32'h0);
    check("lb", load_data, 32'hFFFFFFA5);
    op(1'b0, 2'd0, 1'b1, 8'h09, 32'h0);
    check("lbu", load_data, 32'h000000A5);
    op(1'b0, 2'd1, 1'b0, 8'h0A, 32'h0);
    check("lh", load_data, 32'h00001122);
    op(1'b1, 2'd1, 1'b0, 8'h0A, 32'h00008001);
    op(1'b0, 2'd2, 1'b0, 8'h08, 32'h0);
    check("sh_lw", load_data, 32'h8001A544);
    op(1'b0, 2'd2, 1'b0, 8'h06, 32'h0);
    op(1'b0, 2'd1, 1'b0, 8'h03, 32'h0);
    op(1'b0, 2'd3, 1'b0, 8'h08, 32'h0);
    op(1'b1, 2'd3, 1'b0, 8'h08, 32'h12345678);

    op(1'b0, 2'd2, 1'b0, 8'h08, 32'h0);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size = 2'd0;
    req_addr = 8'h08;
    req_wdata = 32'h000000FF;
    @(posedge clk);
    #1;
    check("pre_rst_wr", {31'b0, mem_write}, 32'h1);
    reset = 1'b0;
    #1;
    check("rst_wr_drop", {31'b0, mem_write}, 32'h0);
    check("rst_rd_drop", {31'b0, mem_read}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("mid_stall", {31'b0, stall}, 32'h0);
    check("mid_lv", {31'b0, load_valid}, 32'h0);
    check("mid_ld", load_data, 32'h0);
    check("mid_mis", {31'b0, misalign}, 32'h0);
    check("mid_rd", {31'b0, mem_read}, 32'h0);
    check("mid_wr", {31'b0, mem_write}, 32'h0);
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    op(1'b0, 2'd2, 1'b0, 8'h08, 32'h0);
    check("rst_old", load_data, 32'h8001A544);

    for (int n = 0; n < 200; n++) begin
      op(1'($urandom_range(0, 1)),
         2'($urandom_range(0, 3)),
         1'($urandom_range(0, 1)),
         8'($urandom_range(0, 31)),
         $urandom);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected done");
    $fatal(1, "timeout");
  end

endmodule
